// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - synchronizes PLL lock and sequences the core reset
// Release needs a continuous lock run plus a settling hold; any lock drop restarts from WAIT_LOCK.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 64,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  sys_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  ready_pulse,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [1:0]            state
);

    localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic                    sys_rst_q, sys_rst_d;
    logic                    sys_rst_n_q;
    logic                    ready_q, ready_d;
    logic                    ready_pulse_q, ready_pulse_d;
    logic                    locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], pll_locked};
        state_d       = state_q;
        cnt_d         = cnt_q;
        loss_d        = loss_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Only a genuine loss from RUN counts; qualification glitches do not.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        sys_rst_d     = (state_d != ST_RUN);
        ready_d       = (state_d == ST_RUN);
        ready_pulse_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT_LOCK;
            sync_q        <= '0;
            cnt_q         <= '0;
            loss_q        <= '0;
            sys_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            ready_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            loss_q        <= loss_d;
            sys_rst_q     <= sys_rst_d;
            sys_rst_n_q   <= ~sys_rst_d;
            ready_q       <= ready_d;
            ready_pulse_q <= ready_pulse_d;
        end
    end

    assign sys_rst         = sys_rst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign ready           = ready_q;
    assign ready_pulse     = ready_pulse_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - bench for pll_reset_sequencer against a lock-streak model
// The model tracks how many consecutive edges the synchronized lock has been seen high.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LOCK = 8;
    localparam int HOLD = 4;
    localparam int LW   = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_n;
    logic          pll;
    logic          sys_rst, sys_rst_n, ready, ready_pulse;
    logic [LW-1:0] llc;
    logic [1:0]    st;

    logic          rst_nd;
    logic          plld;
    logic          sys_rst_dd, sys_rst_n_dd, ready_dd, ready_pulse_dd;
    logic [7:0]    llc_dd;
    logic [1:0]    st_dd;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .LOCK_CYCLES(LOCK), .HOLD_CYCLES(HOLD), .LOSS_CNT_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll),
        .sys_rst(sys_rst), .sys_rst_n(sys_rst_n), .ready(ready),
        .ready_pulse(ready_pulse), .lock_loss_count(llc), .state(st)
    );

    pll_reset_sequencer dut_def (
        .clk(clk), .rst_n(rst_nd), .pll_locked(plld),
        .sys_rst(sys_rst_dd), .sys_rst_n(sys_rst_n_dd), .ready(ready_dd),
        .ready_pulse(ready_pulse_dd), .lock_loss_count(llc_dd), .state(st_dd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int hist[$];
    int streak;
    int m_loss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < SYNC; i++) hist.push_back(0);
        streak = 0;
        m_loss = 0;
    endtask

    task automatic check_model(input string tag);
        int exp_state;
        logic exp_rst;
        if (streak == 0)                exp_state = 0;
        else if (streak <= LOCK)        exp_state = 1;
        else if (streak <= LOCK + HOLD) exp_state = 2;
        else                            exp_state = 3;
        exp_rst = (streak <= LOCK + HOLD);
        check({tag, ".state"},     32'(st),          32'(exp_state));
        check({tag, ".sys_rst"},   32'(sys_rst),     32'(exp_rst));
        check({tag, ".sys_rst_n"}, 32'(sys_rst_n),   32'(!exp_rst));
        check({tag, ".ready"},     32'(ready),       32'(!exp_rst));
        check({tag, ".pulse"},     32'(ready_pulse), 32'(streak == LOCK + HOLD + 1));
        check({tag, ".loss"},      32'(llc),         32'(m_loss));
    endtask

    // Called at a negedge; drives pll for the next edge and checks after it.
    task automatic step(input logic v, input string tag);
        int ls;
        pll = v;
        @(posedge clk);
        ls = hist[0];
        void'(hist.pop_front());
        hist.push_back(int'(v));
        if (ls != 0) begin
            if (streak < LOCK + HOLD + 2) streak++;
        end else begin
            if (streak > LOCK + HOLD && m_loss < (1 << LW) - 1) m_loss++;
            streak = 0;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset(input logic v);
        rst_n = 1'b0;
        pll   = v;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst.sys_rst",   32'(sys_rst),     32'd1);
        check("rst.sys_rst_n", 32'(sys_rst_n),   32'd0);
        check("rst.ready",     32'(ready),       32'd0);
        check("rst.pulse",     32'(ready_pulse), 32'd0);
        check("rst.loss",      32'(llc),         32'd0);
        check("rst.state",     32'(st),          32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int fall_at;
        int pulses;
        rst_n  = 1'b0;
        pll    = 1'b0;
        rst_nd = 1'b0;
        plld   = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with lock held, then qualify
        do_reset(1'b1);
        fall_at = -1;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "qual");
            if (fall_at < 0 && !sys_rst) fall_at = i;
            if (ready_pulse) pulses++;
        end
        check("qual.fall_edge", 32'(fall_at), 32'd14);
        check("qual.pulses",    32'(pulses),  32'd1);
        check("qual.state",     32'(st),      32'd3);

        // Glitch during STABLE
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, "glitch.pre");
        for (int i = 0; i < 3; i++) step(1'b0, "glitch.low");
        check("glitch.state_back", 32'(st), 32'd0);
        fall_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "glitch.post");
            if (fall_at < 0 && !sys_rst) fall_at = i;
        end
        check("glitch.fall_edge", 32'(fall_at), 32'd14);
        check("glitch.loss",      32'(llc),     32'd0);

        // Loss in RUN, then re-lock
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "loss.drop");
            if (i == 1) check("loss.edge1_rst", 32'(sys_rst), 32'd0);
            if (i == 2) begin
                check("loss.edge2_rst",   32'(sys_rst), 32'd1);
                check("loss.edge2_ready", 32'(ready),   32'd0);
                check("loss.edge2_count", 32'(llc),     32'd1);
            end
        end
        fall_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "loss.relock");
            if (fall_at < 0 && !sys_rst) fall_at = i;
        end
        check("loss.relock_edge", 32'(fall_at), 32'd14);

        // Async reset mid-HOLD with a nonzero loss count
        for (int i = 0; i < 3; i++) step(1'b0, "ahold.drop");
        for (int i = 0; i < 12; i++) step(1'b1, "ahold.lock");
        check("ahold.in_hold", 32'(st),  32'd2);
        check("ahold.loss_nz", 32'(llc), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("ahold.sys_rst", 32'(sys_rst), 32'd1);
        check("ahold.state",   32'(st),      32'd0);
        check("ahold.loss",    32'(llc),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Saturation of the loss counter
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 16; i++) step(1'b1, "sat.lock");
            for (int i = 0; i < 4; i++) step(1'b0, "sat.drop");
            check("sat.count", 32'(llc), 32'((k < 3) ? k : 3));
        end

        // Randomized lock/loss pattern
        do_reset(1'b0);
        for (int r = 0; r < 60; r++) begin
            int hi_len;
            int lo_len;
            hi_len = int'($urandom_range(0, 25));
            lo_len = int'($urandom_range(1, 4));
            for (int i = 0; i < hi_len; i++) step(1'b1, "rand.hi");
            for (int i = 0; i < lo_len; i++) step(1'b0, "rand.lo");
        end

        // Default parameters, continuous lock
        plld   = 1'b1;
        rst_nd = 1'b1;
        fall_at = -1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (fall_at < 0 && !sys_rst_dd) fall_at = i;
        end
        check("def.fall_edge", 32'(fall_at), 32'd1090);
        check("def.ready",     32'(ready_dd), 32'd1);
        check("def.state",     32'(st_dd),    32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Turns the PLL's asynchronous `locked` flag into a clean, sequenced system reset for the core. It synchronizes `locked`, requires a run of continuous lock before releasing reset, holds reset for a settling interval, and re-asserts reset on any lock loss. It sits directly downstream of the PLL wrapper. It is clocked by the free-running 50 MHz board reference that also feeds the PLL, so it keeps running while the PLL is unlocked.

## Interface
- `SYNC_STAGES`, 2: number of synchronizer flops on `pll_locked`; must be ≥2.
- `LOCK_CYCLES`, 1024: consecutive synchronized-locked cycles required before the hold phase; must be ≥1.
- `HOLD_CYCLES`, 64: cycles reset stays asserted after lock is qualified; must be ≥1.
- `LOSS_CNT_W`, 8: width of the lock-loss counter.

- `clk`  in  1  free-running 50 MHz reference clock.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous. The top level deasserts it synchronously to `clk`.
- `pll_locked`  in  1  PLL lock flag; asynchronous to `clk`.
- `sys_rst`  out  1  active-high core reset, registered.
- `sys_rst_n`  out  1  always `~sys_rst`, registered.
- `ready`  out  1  high while in RUN.
- `ready_pulse`  out  1  one-cycle pulse on entry to RUN.
- `lock_loss_count`  out  LOSS_CNT_W  number of RUN→WAIT_LOCK transitions; saturates at all-ones.
- `state`  out  2  debug encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.

## Operation
- Synchronizer: `pll_locked` passes through `SYNC_STAGES` flops, all reset to 0. The last stage is `locked_s`. No other logic samples `pll_locked`.
- One down-counter-free up counter, `cnt`. Its width is clog2(max(LOCK_CYCLES, HOLD_CYCLES)). It is shared by STABLE and HOLD and cleared on every state entry.
- WAIT_LOCK (reset state):
  - `cnt`=0.
  - If `locked_s`=1, go to STABLE.
- STABLE:
  - If `locked_s`=0, go to WAIT_LOCK. This is a glitch; the loss counter does not change.
  - Else if `cnt`==LOCK_CYCLES-1, go to HOLD.
  - Else `cnt`++.
- HOLD:
  - If `locked_s`=0, go to WAIT_LOCK. The loss counter does not change.
  - Else if `cnt`==HOLD_CYCLES-1, go to RUN.
  - Else `cnt`++.
- RUN:
  - If `locked_s`=0, go to WAIT_LOCK.
  - On that transition, `lock_loss_count`++ unless it is already all-ones.
- Outputs are registered and update on the same edge as the state transition:
  - `sys_rst`=1 in every state except RUN.
  - `ready`=1 only in RUN.
  - `ready_pulse`=1 for exactly the first cycle of RUN.
- Reset values while `rst_n`=0, applied to every register:
  - state=WAIT_LOCK, sync flops=0, `cnt`=0.
  - `sys_rst`=1, `sys_rst_n`=0.
  - `ready`=0, `ready_pulse`=0.
  - `lock_loss_count`=0.
- Reset mid-operation: asserting `rst_n` in any state forces all reset values immediately and asynchronously. It does not increment `lock_loss_count`.
- Counter arithmetic never wraps. Exit comparisons are equality, and the counter is cleared on every state entry.

## Timing
- Number `clk` edges from index 0, the first edge after `pll_locked` rises, with `pll_locked` held high.
  - `locked_s`=1 after edge SYNC_STAGES-1.
  - STABLE is entered at edge SYNC_STAGES.
  - HOLD is entered at edge SYNC_STAGES+LOCK_CYCLES.
  - RUN is entered at edge SYNC_STAGES+LOCK_CYCLES+HOLD_CYCLES. `sys_rst` falls and `ready_pulse` rises at this edge.
  - Defaults give edge 1090.
- Lock loss in RUN: number edges from 0 as the first edge after `pll_locked` falls. `sys_rst` rises at edge SYNC_STAGES, and `lock_loss_count` updates on the same edge.
- Any drop of `locked_s` during STABLE or HOLD restarts the full qualification sequence from WAIT_LOCK.
- A low pulse on `pll_locked` shorter than one `clk` period may be missed by the synchronizer. This is accepted.

## Test plan
- Reset check, with SYNC=2, LOCK=8, HOLD=4:
  - Hold `rst_n` low with `pll_locked`=1 → `sys_rst`=1, `ready`=0, count=0, state=0.
  - Release `rst_n`, keep `pll_locked`=1 from edge 0 → `sys_rst` falls at edge 14, `ready_pulse` is high for exactly one cycle, state=3.
- Glitch during STABLE: drop `pll_locked` low for 3 cycles at edge 6, then restore it → state returns to 0 and re-qualifies. `sys_rst` falls 14 edges after the restore. `lock_loss_count` stays 0.
- Loss in RUN: after reaching RUN, drop `pll_locked` → `sys_rst`=1 and `ready`=0 at edge 2. `lock_loss_count`=1. Re-lock → RUN again after 14 edges.
- Saturation, with LOSS_CNT_W=2: cause 5 RUN losses → `lock_loss_count` reads 1, 2, 3, 3, 3.
- Async reset mid-HOLD: pull `rst_n` low between edges → `sys_rst`=1 and state=0 before the next edge. `lock_loss_count` is cleared.
- Defaults check: with default parameters and continuous lock → `sys_rst` falls at edge 1090, never earlier.
